// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus controller slice.
//   ADDRESS_SIZE_DEFAULT : default byte-address width of the memory bus
//   DATA_WIDTH           : bus / RAM word width in bits
//   LANES                : number of byte lanes per word
//   ctrl_state_t         : controller FSM states
package mem_bus_pkg;

  localparam int unsigned ADDRESS_SIZE_DEFAULT = 15;
  localparam int unsigned DATA_WIDTH           = 32;
  localparam int unsigned LANES                = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    RESPOND = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/bsram_sp.sv
// Single-port synchronous RAM, one 32-bit word per address, per-byte write
// enables, one-cycle read latency. No reset on the array or the read
// register so it maps onto block RAM.
//   clock       : RAM clock
//   enable      : port enable; reads and writes happen only when high
//   write_lanes : per-byte write enables (bit n -> write_data[8n+7:8n])
//   word_addr   : word index
//   write_data  : data to write
//   read_data   : word at word_addr, one cycle after an enabled access
module bsram_sp
  import mem_bus_pkg::*;
#(
  parameter int unsigned WORD_ADDR_SIZE = 11
) (
  input  logic                      clock,
  input  logic                      enable,
  input  logic [LANES-1:0]          write_lanes,
  input  logic [WORD_ADDR_SIZE-1:0] word_addr,
  input  logic [DATA_WIDTH-1:0]     write_data,
  output logic [DATA_WIDTH-1:0]     read_data
);

  logic [DATA_WIDTH-1:0] mem [0:(2**WORD_ADDR_SIZE)-1];

  always_ff @(posedge clock) begin
    if (enable) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        if (write_lanes[n]) begin
          mem[word_addr][8*n +: 8] <= write_data[8*n +: 8];
        end
      end
      read_data <= mem[word_addr];
    end
  end

endmodule

// File: rtl/bus_memory_ctrl.sv
// Memory bus slave: 4-phase strobe/ready handshake in front of a
// single-port block RAM.
//   clock       : single clock, rising edge
//   reset       : asynchronous, active-low
//   strobe      : transaction request, held until ready is seen
//   writeEnable : 1 = write, 0 = read (valid while strobe=1)
//   address     : byte address; bits [1:0] ignored
//   byteEnable  : write lane mask
//   dataWrite   : write data
//   dataRead    : registered read data, valid while ready=1
//   ready       : registered transaction-complete acknowledge
module bus_memory_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE   = ADDRESS_SIZE_DEFAULT,
  parameter int unsigned WORD_ADDR_SIZE = 11
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    strobe,
  input  logic                    writeEnable,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic [LANES-1:0]        byteEnable,
  input  logic [DATA_WIDTH-1:0]   dataWrite,
  output logic [DATA_WIDTH-1:0]   dataRead,
  output logic                    ready
);

  ctrl_state_t           state;
  logic                  read_in_range;
  logic                  in_range;
  logic                  accept;
  logic [LANES-1:0]      ram_lanes;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  addr_lsb_unused;

  // Byte offset within a word has no effect on the access.
  assign addr_lsb_unused = ^address[1:0];

  assign in_range  = (address[ADDRESS_SIZE-1:WORD_ADDR_SIZE+2] == '0);
  // The RAM port is only touched on the accepting edge, so request-side
  // changes in READ/RESPOND cannot reach the array. strobe feeds only the
  // RAM port here; ready comes solely from the FSM register.
  assign accept    = (state == IDLE) && strobe;
  assign ram_lanes = (writeEnable && in_range) ? byteEnable : '0;

  bsram_sp #(
    .WORD_ADDR_SIZE(WORD_ADDR_SIZE)
  ) u_ram (
    .clock      (clock),
    .enable     (accept),
    .write_lanes(ram_lanes),
    .word_addr  (address[WORD_ADDR_SIZE+1:2]),
    .write_data (dataWrite),
    .read_data  (ram_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ready         <= 1'b0;
      dataRead      <= '0;
      read_in_range <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            if (writeEnable) begin
              state <= RESPOND;
              ready <= 1'b1;
            end else begin
              state         <= READ;
              read_in_range <= in_range;
            end
          end
        end
        READ: begin
          if (!strobe) begin
            state <= IDLE;
          end else begin
            dataRead <= read_in_range ? ram_rdata : '0;
            ready    <= 1'b1;
            state    <= RESPOND;
          end
        end
        RESPOND: begin
          if (!strobe) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_memory_ctrl.sv
// Self-checking bench for bus_memory_ctrl: directed scenarios plus a
// randomized phase checked against a word-array reference model.
module tb_bus_memory_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        strobe = 1'b0;
  logic        writeEnable = 1'b0;
  logic [14:0] address = '0;
  logic [3:0]  byteEnable = '0;
  logic [31:0] dataWrite = '0;
  logic [31:0] dataRead;
  logic        ready;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem_model [0:2047];
  logic [31:0] exp_dr = '0;

  always #5 clock = ~clock;

  bus_memory_ctrl #(
    .ADDRESS_SIZE(15),
    .WORD_ADDR_SIZE(11)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .strobe     (strobe),
    .writeEnable(writeEnable),
    .address    (address),
    .byteEnable (byteEnable),
    .dataWrite  (dataWrite),
    .dataRead   (dataRead),
    .ready      (ready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
    $fatal(1);
  end

  // Reference model: 8 KiB of 32-bit words; anything at or above 8192 is unmapped.
  function automatic void model_write(input int a, input logic [3:0] be, input logic [31:0] d);
    if (a < 8192) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) mem_model[a / 4][8*n +: 8] = d[8*n +: 8];
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input int a);
    return (a < 8192) ? mem_model[a / 4] : 32'h0;
  endfunction

  // One full handshake starting and ending on a falling edge.
  task automatic xact(input logic we, input logic [14:0] a, input logic [3:0] be,
                      input logic [31:0] d, output logic [31:0] rd, output int lat,
                      output logic ready_after);
    strobe = 1'b1; writeEnable = we; address = a; byteEnable = be; dataWrite = d;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!ready && lat < 8);
    rd = dataRead;
    strobe = 1'b0;
    writeEnable = 1'($urandom); address = 15'($urandom);
    byteEnable = 4'($urandom); dataWrite = $urandom;
    @(negedge clock);
    ready_after = ready;
    if (we) model_write(int'(a), be, d);
    else exp_dr = model_read(int'(a));
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else passed++;
    total++;
    if (dataRead !== 32'h0) $display("FAIL reset_data: got %h want 00000000", dataRead); else passed++;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", ready); else passed++;
  endtask

  task automatic test_write_read;
    logic [31:0] rd; int lat; logic ra;
    xact(1'b1, 15'h0010, 4'hF, 32'hDEADBEEF, rd, lat, ra);
    total++;
    if (lat !== 1) $display("FAIL wr_latency: got %0d want 1", lat); else passed++;
    total++;
    if (ra !== 1'b0) $display("FAIL wr_ready_drop: got %b want 0", ra); else passed++;
    xact(1'b0, 15'h0010, 4'h0, 32'h0, rd, lat, ra);
    total++;
    if (lat !== 2) $display("FAIL rd_latency: got %0d want 2", lat); else passed++;
    total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else passed++;
    total++;
    if (ra !== 1'b0) $display("FAIL rd_ready_drop: got %b want 0", ra); else passed++;
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd; int lat; logic ra;
    xact(1'b1, 15'h0010, 4'b0001, 32'h000000AA, rd, lat, ra);
    xact(1'b0, 15'h0013, 4'h0, 32'h0, rd, lat, ra);
    total++;
    if (rd !== 32'hDEADBEAA) $display("FAIL lane_merge: got %h want deadbeaa", rd); else passed++;
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; int lat; logic ra;
    xact(1'b1, 15'h0000, 4'hF, 32'h11223344, rd, lat, ra);
    xact(1'b0, 15'h4000, 4'h0, 32'h0, rd, lat, ra);
    total++;
    if (rd !== 32'h0) $display("FAIL oor_read_data: got %h want 00000000", rd); else passed++;
    total++;
    if (lat !== 2) $display("FAIL oor_read_latency: got %0d want 2", lat); else passed++;
    xact(1'b1, 15'h4000, 4'hF, 32'hFFFFFFFF, rd, lat, ra);
    total++;
    if (lat !== 1) $display("FAIL oor_write_latency: got %0d want 1", lat); else passed++;
    xact(1'b0, 15'h0000, 4'h0, 32'h0, rd, lat, ra);
    total++;
    if (rd !== 32'h11223344) $display("FAIL oor_write_dropped: got %h want 11223344", rd); else passed++;
  endtask

  task automatic test_zero_be;
    logic [31:0] rd; int lat; logic ra;
    xact(1'b1, 15'h0010, 4'b0000, 32'h55555555, rd, lat, ra);
    total++;
    if (lat !== 1) $display("FAIL zero_be_latency: got %0d want 1", lat); else passed++;
    xact(1'b0, 15'h0010, 4'h0, 32'h0, rd, lat, ra);
    total++;
    if (rd !== 32'hDEADBEAA) $display("FAIL zero_be_unchanged: got %h want deadbeaa", rd); else passed++;
  endtask

  task automatic test_hold;
    logic [31:0] rd; int lat; logic ra;
    logic [31:0] held;
    strobe = 1'b1; writeEnable = 1'b0; address = 15'h0010; byteEnable = 4'h0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!ready && lat < 8);
    total++;
    if (lat !== 2) $display("FAIL hold_latency: got %0d want 2", lat); else passed++;
    held = model_read(16);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clock);
      total++;
      if (ready !== 1'b1 || dataRead !== held)
        $display("FAIL hold_cycle%0d: got ready=%b data=%h want ready=1 data=%h", c, ready, dataRead, held);
      else passed++;
      // Request-side noise while the response is held must be ignored.
      writeEnable = 1'b1; byteEnable = 4'hF; address = 15'h0010; dataWrite = $urandom;
    end
    strobe = 1'b0;
    @(negedge clock);
    total++;
    if (ready !== 1'b0) $display("FAIL hold_release: got %b want 0", ready); else passed++;
    exp_dr = held;
    xact(1'b0, 15'h0010, 4'h0, 32'h0, rd, lat, ra);
    total++;
    if (lat !== 2 || rd !== held)
      $display("FAIL hold_next_req: got lat=%0d data=%h want lat=2 data=%h", lat, rd, held);
    else passed++;
  endtask

  task automatic test_abort;
    logic [31:0] rd; int lat; logic ra;
    strobe = 1'b1; writeEnable = 1'b0; address = 15'h0000;
    @(negedge clock);
    total++;
    if (ready !== 1'b0) $display("FAIL abort_read_state: got %b want 0", ready); else passed++;
    strobe = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      total++;
      if (ready !== 1'b0 || dataRead !== exp_dr)
        $display("FAIL abort_quiet%0d: got ready=%b data=%h want ready=0 data=%h", c, ready, dataRead, exp_dr);
      else passed++;
    end
    xact(1'b0, 15'h0000, 4'h0, 32'h0, rd, lat, ra);
    total++;
    if (lat !== 2 || rd !== 32'h11223344)
      $display("FAIL abort_followup: got lat=%0d data=%h want lat=2 data=11223344", lat, rd);
    else passed++;
    // Write strobe withdrawn right after acceptance still commits.
    strobe = 1'b1; writeEnable = 1'b1; address = 15'h0004; byteEnable = 4'hF; dataWrite = 32'hCAFEF00D;
    @(negedge clock);
    strobe = 1'b0;
    model_write(4, 4'hF, 32'hCAFEF00D);
    @(negedge clock);
    xact(1'b0, 15'h0004, 4'h0, 32'h0, rd, lat, ra);
    total++;
    if (rd !== 32'hCAFEF00D) $display("FAIL write_abort_commit: got %h want cafef00d", rd); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int lat; logic ra;
    for (int k = 0; k < 4; k++) begin
      logic [14:0] a;
      logic [31:0] d;
      a = 15'($urandom_range(0, 8191));
      d = $urandom;
      xact(1'b1, a, 4'hF, d, rd, lat, ra);
      xact(1'b0, a, 4'h0, 32'h0, rd, lat, ra);
      total++;
      if (rd !== d) $display("FAIL b2b_%0d: addr %h got %h want %h", k, a, rd, d); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int lat; logic ra;
    xact(1'b1, 15'h0020, 4'hF, 32'h12345678, rd, lat, ra);
    xact(1'b0, 15'h0004, 4'h0, 32'h0, rd, lat, ra);
    strobe = 1'b1; writeEnable = 1'b0; address = 15'h0020;
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0 || dataRead !== 32'h0)
      $display("FAIL reset_mid: got ready=%b data=%h want ready=0 data=00000000", ready, dataRead);
    else passed++;
    @(negedge clock);
    reset = 1'b1;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!ready && lat < 8);
    total++;
    if (lat !== 2 || dataRead !== 32'h12345678)
      $display("FAIL reset_release_read: got lat=%0d data=%h want lat=2 data=12345678", lat, dataRead);
    else passed++;
    strobe = 1'b0;
    @(negedge clock);
    exp_dr = 32'h12345678;
  endtask

  task automatic test_random;
    logic [31:0] rd; int lat; logic ra;
    for (int w = 0; w < 64; w++) xact(1'b1, 15'(w * 4), 4'hF, $urandom, rd, lat, ra);
    for (int k = 0; k < 200; k++) begin
      logic        we;
      logic [14:0] a;
      logic [3:0]  be;
      logic [31:0] d;
      logic [31:0] expect_rd;
      we = 1'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(8192, 32767)) : 15'($urandom_range(0, 255));
      be = 4'($urandom);
      d  = $urandom;
      expect_rd = model_read(int'(a));
      xact(we, a, be, d, rd, lat, ra);
      total++;
      if (lat !== (we ? 1 : 2) || ra !== 1'b0)
        $display("FAIL rnd_hs_%0d: got lat=%0d ready_after=%b want lat=%0d ready_after=0", k, lat, ra, we ? 1 : 2);
      else passed++;
      if (!we) begin
        total++;
        if (rd !== expect_rd) $display("FAIL rnd_rd_%0d: addr %h got %h want %h", k, a, rd, expect_rd);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_lanes;
    test_out_of_range;
    test_zero_be;
    test_hold;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
